// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared FSM state type and default parameters for the context register file
package regfile_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_CTX_REGS   = 15;
    localparam int DEF_CTX_DEPTH  = 4;
    localparam int DEF_IO_IN_REG  = 15;
    localparam int DEF_IO_OUT_REG = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } ctx_state_e;

endpackage

// File: rtl/regfile_ctx_if.sv
// rtl/regfile_ctx_if.sv - register port, I/O and context request bundle
interface regfile_ctx_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LVL_W  = $clog2(DEF_CTX_DEPTH + 1)
);
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [DATA_W-1:0] w1;
    logic [DATA_W-1:0] w2;
    logic              w1En;
    logic              w2En;
    logic              r1En;
    logic              r2En;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] ioIn;
    logic [DATA_W-1:0] ioOut;
    logic              saveReq;
    logic              restoreReq;
    logic              ctxBusy;
    logic              ctxDone;
    logic              ctxErr;
    logic [LVL_W-1:0]  ctxLevel;

    modport slave (
        input  a1, a2, w1, w2, w1En, w2En, r1En, r2En, ioIn, saveReq, restoreReq,
        output r1, r2, ioOut, ctxBusy, ctxDone, ctxErr, ctxLevel
    );

    modport master (
        output a1, a2, w1, w2, w1En, w2En, r1En, r2En, ioIn, saveReq, restoreReq,
        input  r1, r2, ioOut, ctxBusy, ctxDone, ctxErr, ctxLevel
    );

endinterface

// File: rtl/ctx_stack.sv
// rtl/ctx_stack.sv - context frame storage with push/pop level pointer
module ctx_stack
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CTX_REGS  = DEF_CTX_REGS,
    parameter int CTX_DEPTH = DEF_CTX_DEPTH,
    localparam int IDX_W    = (CTX_REGS > 1) ? $clog2(CTX_REGS) : 1,
    localparam int LVL_W    = $clog2(CTX_DEPTH + 1),
    localparam int FR_W     = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [LVL_W-1:0]  level_o
);
    logic [DATA_W-1:0] frame_q [CTX_DEPTH][CTX_REGS];
    logic [LVL_W-1:0]  level_q;
    logic [FR_W-1:0]   wr_fr;
    logic [FR_W-1:0]   rd_fr;

    // Saves fill the frame at the current level; restores drain the frame just below it.
    assign wr_fr     = level_q[FR_W-1:0];
    assign rd_fr     = wr_fr - FR_W'(1);
    assign rd_data_o = frame_q[rd_fr][idx_i];
    assign level_o   = level_q;

    // Frame slot writes and level update; level only moves on the final copy cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int f = 0; f < CTX_DEPTH; f++) begin
                for (int s = 0; s < CTX_REGS; s++) begin
                    frame_q[f][s] <= '0;
                end
            end
            level_q <= '0;
        end else begin
            if (wr_en_i) begin
                frame_q[wr_fr][idx_i] <= wr_data_i;
            end
            if (push_i) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop_i) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_ctx.sv
// rtl/regfile_ctx.sv - dual-port register file with I/O registers and context save/restore
module regfile_ctx
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CTX_REGS   = DEF_CTX_REGS,
    parameter int CTX_DEPTH  = DEF_CTX_DEPTH,
    parameter int IO_IN_REG  = DEF_IO_IN_REG,
    parameter int IO_OUT_REG = DEF_IO_OUT_REG,
    parameter int ZERO_REG   = (2**ADDR_W) - 1
) (
    input  logic         clk,
    input  logic         resetN,
    regfile_ctx_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int IDX_W = (CTX_REGS > 1) ? $clog2(CTX_REGS) : 1;
    localparam int LVL_W = $clog2(CTX_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] IO_IN_A  = ADDR_W'(IO_IN_REG);
    localparam logic [ADDR_W-1:0] IO_OUT_A = ADDR_W'(IO_OUT_REG);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(CTX_REGS - 1);
    localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(CTX_DEPTH);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] r1_q;
    logic [DATA_W-1:0] r2_q;
    logic [DATA_W-1:0] io_out_q;
    ctx_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [ADDR_W-1:0] idx_addr;
    logic [DATA_W-1:0] stk_rd_data;
    logic [LVL_W-1:0]  level;
    logic              last_copy;
    logic              w1_ok;
    logic              w2_ok;

    assign idx_addr  = ADDR_W'(idx_q);
    assign last_copy = (idx_q == IDX_LAST);
    assign w1_ok     = bus.w1En && !busy_q && (bus.a1 != ZERO_A) && (bus.a1 != IO_IN_A);
    assign w2_ok     = bus.w2En && !busy_q && (bus.a2 != ZERO_A) && (bus.a2 != IO_IN_A);

    ctx_stack #(
        .DATA_W    (DATA_W),
        .CTX_REGS  (CTX_REGS),
        .CTX_DEPTH (CTX_DEPTH)
    ) u_stack (
        .clk       (clk),
        .resetN    (resetN),
        .wr_en_i   (state_q == ST_SAVE),
        .idx_i     (idx_q),
        .wr_data_i (regs_q[idx_addr]),
        .push_i    ((state_q == ST_SAVE) && last_copy),
        .pop_i     ((state_q == ST_RESTORE) && last_copy),
        .rd_data_o (stk_rd_data),
        .level_o   (level)
    );

    // Register array: port writes (port 2 last so it wins), restore copy, then ioIn load on top.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (w1_ok) begin
                regs_q[bus.a1] <= bus.w1;
            end
            if (w2_ok) begin
                regs_q[bus.a2] <= bus.w2;
            end
            if (state_q == ST_RESTORE) begin
                regs_q[idx_addr] <= stk_rd_data;
            end
            regs_q[IO_IN_A] <= bus.ioIn;
        end
    end

    // Registered read ports and I/O output mirror; reads see pre-write contents.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r1_q     <= '0;
            r2_q     <= '0;
            io_out_q <= '0;
        end else begin
            if (bus.r1En) begin
                r1_q <= (bus.a1 == ZERO_A) ? '0 : regs_q[bus.a1];
            end
            if (bus.r2En) begin
                r2_q <= (bus.a2 == ZERO_A) ? '0 : regs_q[bus.a2];
            end
            io_out_q <= regs_q[IO_OUT_A];
        end
    end

    // Context FSM: restore has priority, one register copied per cycle, single-cycle done/err pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.restoreReq) begin
                        if (level != '0) begin
                            state_q <= ST_RESTORE;
                            busy_q  <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (bus.saveReq) begin
                        if (level < LVL_MAX) begin
                            state_q <= ST_SAVE;
                            busy_q  <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SAVE, ST_RESTORE: begin
                    if (last_copy) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r1       = r1_q;
    assign bus.r2       = r2_q;
    assign bus.ioOut    = io_out_q;
    assign bus.ctxBusy  = busy_q;
    assign bus.ctxDone  = done_q;
    assign bus.ctxErr   = err_q;
    assign bus.ctxLevel = level;

endmodule

// File: doc/regfile_ctx.md
REGFILE_CTX -- requirements
Module: regfile_ctx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter CTX_REGS, default 15, registers 0..CTX_REGS-1 form the saved context.
REQ-004 SHALL have parameter CTX_DEPTH, default 4, number of context frames held internally.
REQ-005 SHALL have parameters IO_IN_REG (15), IO_OUT_REG (16) and ZERO_REG (DEPTH-1), the special register indices.
REQ-006 SHALL have ports: clk in 1, clock; resetN in 1, reset (one clock; reset asynchronous, active-low).
REQ-007 SHALL have ports: a1, a2 in ADDR_W, port addresses; w1, w2 in DATA_W, write data; w1En, w2En, r1En, r2En in 1, enables.
REQ-008 SHALL have ports: r1, r2 out DATA_W, registered read data; ioIn in DATA_W, external input; ioOut out DATA_W, external output.
REQ-009 SHALL have ports: saveReq, restoreReq in 1, context push/pop requests.
REQ-010 SHALL have ports: ctxBusy out 1, copy in progress; ctxDone out 1, completion pulse; ctxErr out 1, overflow/underflow pulse; ctxLevel out $clog2(CTX_DEPTH+1), frames held.

Function
REQ-011 Reads SHALL have 1-cycle latency: rN updates on the clock edge where rNEn=1 and holds its value otherwise.
REQ-012 A read of ZERO_REG SHALL return 0 on that port only; writes to ZERO_REG SHALL be ignored.
REQ-013 A read and a write to the same address in the same cycle SHALL return the old value.
REQ-014 When w1En and w2En target the same address, w2 SHALL win.
REQ-015 Register IO_IN_REG SHALL load ioIn every cycle; port writes to it SHALL be ignored.
REQ-016 ioOut SHALL be a registered copy of IO_OUT_REG: 1 cycle behind any write.
REQ-017 FSM states: IDLE, SAVE, RESTORE; a 'copy index' counter runs 0..CTX_REGS-1.
REQ-018 IDLE with saveReq=1 and ctxLevel<CTX_DEPTH: go to SAVE; copy register idx to frame[ctxLevel] slot idx, one register per cycle.
REQ-019 IDLE with restoreReq=1 and ctxLevel>0: go to RESTORE; copy frame[ctxLevel-1] slot idx to register idx, one per cycle.
REQ-020 After index CTX_REGS-1: return to IDLE. ctxLevel SHALL increment after SAVE or decrement after RESTORE. ctxDone SHALL pulse for 1 cycle.
REQ-021 ctxBusy SHALL be high in SAVE/RESTORE (exactly CTX_REGS cycles). Port writes SHALL be ignored while busy; reads still serviced.
REQ-022 Both requests in IDLE: restoreReq SHALL take priority; saveReq dropped.
REQ-023 saveReq at ctxLevel=CTX_DEPTH, or restoreReq at ctxLevel=0: no state change; ctxErr SHALL pulse 1 cycle.
REQ-024 Requests arriving while busy SHALL be ignored without error.
REQ-025 ioIn loading of IO_IN_REG SHALL continue during RESTORE and SHALL override a restored value when IO_IN_REG<CTX_REGS.

Reset
REQ-026 resetN low SHALL asynchronously clear all registers, frames, r1, r2, ioOut, ctxLevel, index and flags, and SHALL force IDLE.
REQ-027 Reset during SAVE/RESTORE SHALL abort the copy; no partial level change SHALL survive.

Structure
REQ-028 The FSM state enum and default parameter constants SHALL live in shared package regfile_pkg.
REQ-029 The frame storage with its push/pop pointer SHALL be a sub-module ctx_stack; the register array, ports and FSM SHALL stay in regfile_ctx.

Verification
REQ-030 Write reg 3=0x1234 via port 1; read a1=3 next cycle -> r1=0x1234 one cycle later; read a2=63 -> r2=0.
REQ-031 Load regs 0..14 with 0x0100+i; pulse saveReq; overwrite all with 0xFFFF; pulse restoreReq -> ctxBusy high 15 cycles each time, ctxDone pulses, ctxLevel 0->1->0, regs read 0x0100+i.
REQ-032 Perform 4 saves, then a 5th -> ctxErr pulse, ctxLevel stays 4; with ctxLevel=0, restoreReq -> ctxErr pulse.
REQ-033 ioIn=0xBEEF -> read reg 15 = 0xBEEF; write reg 16=0x00AA -> ioOut=0x00AA one cycle later.
REQ-034 saveReq and restoreReq together at ctxLevel=1 -> RESTORE taken and ctxLevel=0; assert resetN low mid-SAVE -> ctxBusy=0, ctxLevel=0, all reads 0.
